// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer for the serial CRC-8 checker: clears it, streams one framed
// bitstream into it under valid/ready, captures the result and counts failures.
module crc8_frame_ctrl #(
  parameter int FRAME_BITS = 24,
  parameter int CNT_W      = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       bit_i,
  input  logic       bit_valid_i,
  output logic       bit_ready_o,
  output logic       crc_clr_o,
  output logic       crc_en_o,
  output logic       crc_data_o,
  output logic       crc_capture_o,
  input  logic       crc_flag_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] err_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SHIFT, CAPTURE, WAIT_FLAG, DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             last_bit;

  // The handshake only completes in SHIFT, which is exactly where ready is high.
  assign accept   = (state == SHIFT) && bit_valid_i;
  assign last_bit = accept && (bit_cnt == LAST_IDX);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: each always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start_i) next_state = CLEAR;
      CLEAR:     next_state = SHIFT;
      SHIFT:     if (last_bit) next_state = CAPTURE;
      CAPTURE:   next_state = WAIT_FLAG;
      WAIT_FLAG: next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    // Abort overrides every transition, including a simultaneous last-bit accept.
    if (abort_i && state != IDLE) next_state = IDLE;
  end

  always_comb begin
    bit_ready_o   = 1'b0;
    crc_clr_o     = 1'b0;
    crc_capture_o = 1'b0;
    done_o        = 1'b0;
    busy_o        = (state != IDLE);
    crc_en_o      = accept;
    crc_data_o    = accept & bit_i;
    case (state)
      CLEAR:   crc_clr_o     = 1'b1;
      SHIFT:   bit_ready_o   = 1'b1;
      CAPTURE: crc_capture_o = 1'b1;
      DONE:    done_o        = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= '0;
    end else if (state == CLEAR) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Result registers load on the edge entering DONE; an abort leaves them untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_o    <= 1'b0;
      err_cnt_o <= 8'd0;
    end else if (state == WAIT_FLAG && !abort_i) begin
      pass_o <= crc_flag_i;
      if (!crc_flag_i && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Directed bench for crc8_frame_ctrl with a behavioural CRC-8 (x^8+x^2+x+1) checker
// standing in for crc_8; frame timing and results are checked against local expectations.
module tb_crc8_frame_ctrl;

  localparam int FB = 24;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i, abort_i, bit_i, bit_valid_i;
  logic       bit_ready_o, crc_clr_o, crc_en_o, crc_data_o, crc_capture_o;
  logic       crc_flag_i;
  logic       busy_o, done_o, pass_o;
  logic [7:0] err_cnt_o;

  crc8_frame_ctrl #(.FRAME_BITS(FB), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .bit_i(bit_i), .bit_valid_i(bit_valid_i), .bit_ready_o(bit_ready_o),
    .crc_clr_o(crc_clr_o), .crc_en_o(crc_en_o), .crc_data_o(crc_data_o),
    .crc_capture_o(crc_capture_o), .crc_flag_i(crc_flag_i), .busy_o(busy_o),
    .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] r, input logic b);
    logic fb;
    fb = r[7] ^ b;
    return {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] crc_payload(input logic [15:0] d);
    logic [7:0] r = 8'h00;
    for (int i = 15; i >= 0; i--) r = crc_step(r, d[i]);
    return r;
  endfunction

  function automatic logic [7:0] residue(input logic [FB-1:0] f);
    logic [7:0] r = 8'h00;
    for (int i = FB - 1; i >= 0; i--) r = crc_step(r, f[i]);
    return r;
  endfunction

  // Behavioural checker fed by the controller's strobes.
  logic [7:0] model_crc;
  logic       force_fail = 1'b0;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      model_crc  <= 8'h00;
      crc_flag_i <= 1'b0;
    end else begin
      if (crc_clr_o)     model_crc  <= 8'h00;
      else if (crc_en_o) model_crc  <= crc_step(model_crc, crc_data_o);
      if (crc_capture_o) crc_flag_i <= (model_crc == 8'h00) && !force_fail;
    end
  end

  // Cycle counter and strobe monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic mon_clear = 1'b0;
  int clr_cnt, en_cnt, cap_cnt, done_cnt, en_bad;
  int clr_cyc, cap_cyc, done_cyc, start_cyc, first_acc, last_acc;
  always @(negedge clk_i) begin
    if (mon_clear) begin
      clr_cnt <= 0; en_cnt <= 0; cap_cnt <= 0; done_cnt <= 0; en_bad <= 0;
      first_acc <= -1; last_acc <= -1; clr_cyc <= -1; cap_cyc <= -1; done_cyc <= -1;
    end else begin
      if (crc_clr_o)     begin clr_cnt  <= clr_cnt + 1;  clr_cyc  <= cyc; end
      if (crc_en_o)      en_cnt <= en_cnt + 1;
      if (crc_capture_o) begin cap_cnt  <= cap_cnt + 1;  cap_cyc  <= cyc; end
      if (done_o)        begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (crc_en_o != (bit_valid_i && bit_ready_o)) en_bad <= en_bad + 1;
      if (crc_en_o && crc_data_o != bit_i) en_bad <= en_bad + 1;
      if (bit_valid_i && bit_ready_o) begin
        if (first_acc < 0) first_acc <= cyc;
        last_acc <= cyc;
      end
    end
    if (start_i && !busy_o) start_cyc <= cyc;
  end

  logic       exp_pass = 1'b0;
  logic [7:0] exp_err  = 8'd0;

  // Sends one frame; abort_at/reset_at (1-based accepted bit, or -1) cut it short,
  // start_at (0-based bit index, or -1) pulses start_i while that bit is offered.
  task automatic run_frame(input logic [FB-1:0] frm, input bit stall,
                           input int abort_at, input int reset_at, input int start_at);
    int  idx = 0;
    int  budget = 0;
    int  gap_idx = -1;
    bit  acc;
    @(posedge clk_i); #1;
    start_i = 1'b1; mon_clear = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; mon_clear = 1'b0;
    while (idx < FB && budget < 400) begin
      if (stall && (idx == 4 || idx == 12 || idx == 20) && gap_idx != idx) begin
        bit_valid_i = 1'b0;
        repeat ($urandom_range(1, 7)) begin @(posedge clk_i); #1; budget++; end
        gap_idx = idx;
      end
      bit_valid_i = 1'b1;
      bit_i       = frm[FB-1-idx];
      start_i     = (idx == start_at);
      abort_i     = (idx == abort_at - 1);
      if (idx == reset_at - 1) begin
        #2 rst_i = 1'b1;
        #1 check("rst_async_outputs",
                 {busy_o, bit_ready_o, crc_clr_o, crc_en_o, crc_data_o,
                  crc_capture_o, done_o, pass_o, err_cnt_o}, 0);
        bit_valid_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(posedge clk_i); #1 check("rst_idle_after", busy_o, 0);
        exp_pass = 1'b0;
        exp_err  = 8'd0;
        return;
      end
      @(negedge clk_i) acc = bit_ready_o;
      @(posedge clk_i); #1;
      budget++;
      if (acc) idx++;
      start_i = 1'b0;
      if (abort_i) begin
        abort_i = 1'b0;
        bit_valid_i = 1'b0;
        check("abort_busy_next", busy_o, 0);
        repeat (6) @(posedge clk_i); #1;
        check("abort_en_count", en_cnt, abort_at);
        check("abort_no_capture", cap_cnt, 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_pass_held", pass_o, exp_pass);
        check("abort_err_held", err_cnt_o, exp_err);
        return;
      end
    end
    bit_valid_i = 1'b0;
    check("shift_budget", idx, FB);
    repeat (6) @(posedge clk_i); #1;
    exp_pass = (residue(frm) == 8'h00) && !force_fail;
    if (!exp_pass && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    check("clr_pulses", clr_cnt, 1);
    check("clr_latency", clr_cyc - start_cyc, 1);
    if (!stall) check("first_accept_latency", first_acc - start_cyc, 2);
    check("en_count", en_cnt, FB);
    check("en_vs_accept", en_bad, 0);
    check("capture_pulses", cap_cnt, 1);
    check("capture_latency", cap_cyc - last_acc, 1);
    check("done_pulses", done_cnt, 1);
    check("done_latency", done_cyc - last_acc, 3);
    check("pass", pass_o, exp_pass);
    check("err_cnt", err_cnt_o, exp_err);
    check("idle_after_frame", busy_o, 0);
  endtask

  logic [15:0]   pay_a, pay_b, pay_c;
  logic [FB-1:0] frame_a, frame_b, frame_c, frame_bad;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0;
    pay_a = 16'hA53C; pay_b = 16'h1F80; pay_c = 16'hFFFF;
    frame_a   = {pay_a, crc_payload(pay_a)};
    frame_b   = {pay_b, crc_payload(pay_b)};
    frame_c   = {pay_c, crc_payload(pay_c)};
    frame_bad = frame_a ^ (24'h1 << (FB - 1 - 5));
    #1 check("reset_outputs",
             {busy_o, bit_ready_o, crc_clr_o, crc_en_o, crc_data_o,
              crc_capture_o, done_o, pass_o, err_cnt_o}, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    check("idle_no_ready", bit_ready_o, 0);

    run_frame(frame_a, 1'b0, -1, -1, -1);
    check("valid_frame_pass", pass_o, 1);
    run_frame(frame_bad, 1'b0, -1, -1, -1);
    check("corrupt_err_one", err_cnt_o, 1);
    run_frame(frame_b, 1'b1, -1, -1, -1);
    run_frame(frame_b, 1'b0, 10, -1, -1);
    run_frame(frame_c, 1'b0, -1, -1, 5);

    force_fail = 1'b1;
    for (int n = 0; n < 257; n++) run_frame(frame_a, 1'b0, -1, -1, -1);
    check("saturated_err", err_cnt_o, 255);
    force_fail = 1'b0;
    run_frame(frame_a, 1'b0, -1, -1, -1);
    check("pass_after_sat", pass_o, 1);

    run_frame(frame_b, 1'b0, -1, 12, -1);
    run_frame(frame_b, 1'b0, -1, -1, -1);
    check("post_reset_err", err_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
